binary_gcd_engine: RTL

BINARY_GCD_ENGINE -- requirements
Module: binary_gcd_engine

---
 rtl/binary_gcd_engine.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/binary_gcd_engine.sv
// ---------------------------------------------------------------------------
// binary_gcd_engine
//
// Purpose:
//   Computes gcd(OPA, OPB) with the binary (Stein) algorithm. Operands and
//   results are exchanged through a small Avalon-MM CSR block. The engine
//   first strips common factors of two, then reduces the odd parts by
//   shifting and subtracting, and restores the stripped factors at the end.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   csr_read       Avalon-MM read strobe
//   csr_write      Avalon-MM write strobe
//   csr_address    word address (0..7)
//   csr_writedata  write data
//   csr_readdata   registered read data, 1-cycle latency, held between reads
//   irq            level interrupt, irq_en & (done | zero_err)
//
// Register map (word addresses):
//   0 CTRL   bit0 busy (RO), bit1 done (W1C), bit2 zero_err (W1C), bit8 irq_en
//   1 OPA    2 OPB    3 START (WO)    4 RESULT    5 CYCLES    6 PARAM
//   7 constant 32'hDEADBEEF
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for a START write
//   STRIP  | removing common factors of two, counting them in k
//   REDUCE | shrinking the odd parts until a == b
//   DONE   | one cycle; publishes RESULT and raises the sticky flags
// ---------------------------------------------------------------------------
module binary_gcd_engine #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [2:0]  csr_address,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        irq
);

    localparam int KW = $clog2(WIDTH) + 1;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_OPA    = 3'd1;
    localparam logic [2:0] ADDR_OPB    = 3'd2;
    localparam logic [2:0] ADDR_START  = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_CYCLES = 3'd5;
    localparam logic [2:0] ADDR_PARAM  = 3'd6;
    localparam logic [2:0] ADDR_MAGIC  = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIP  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   opa_q,      opa_d;
    logic [WIDTH-1:0]   opb_q,      opb_d;
    logic [WIDTH-1:0]   a_q,        a_d;
    logic [WIDTH-1:0]   b_q,        b_d;
    logic [KW-1:0]      k_q,        k_d;
    logic [WIDTH-1:0]   gcd_q,      gcd_d;
    logic [WIDTH-1:0]   result_q,   result_d;
    logic [15:0]        cycles_q,   cycles_d;
    logic               done_q,     done_d;
    logic               zero_err_q, zero_err_d;
    logic               irq_en_q,   irq_en_d;
    logic [31:0]        rdata_q,    rdata_d;

    logic               busy;
    logic               wr_ctrl;
    logic               wr_opa;
    logic               wr_opb;
    logic               wr_start;
    logic [15:0]        cycles_inc;

    // Only the low WIDTH bits and a few CTRL bits of the write bus are used.
    logic               unused_wdata;
    assign unused_wdata = &{1'b0, csr_writedata};

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] val);
        logic [31:0] r;
        r            = '0;
        r[WIDTH-1:0] = val;
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        gcd_d      = gcd_q;
        result_d   = result_q;
        cycles_d   = cycles_q;
        done_d     = done_q;
        zero_err_d = zero_err_q;
        irq_en_d   = irq_en_q;
        rdata_d    = rdata_q;

        busy       = (state_q != IDLE);
        wr_ctrl    = csr_write && (csr_address == ADDR_CTRL);
        wr_opa     = csr_write && (csr_address == ADDR_OPA);
        wr_opb     = csr_write && (csr_address == ADDR_OPB);
        wr_start   = csr_write && (csr_address == ADDR_START);
        cycles_inc = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

        // CTRL is handled before the FSM so a set in DONE overrides a
        // same-cycle W1C clear.
        if (wr_ctrl) begin
            irq_en_d = csr_writedata[8];
            if (csr_writedata[1]) begin
                done_d = 1'b0;
            end
            if (csr_writedata[2]) begin
                zero_err_d = 1'b0;
            end
        end

        if (wr_opa && !busy) begin
            opa_d = csr_writedata[WIDTH-1:0];
        end
        if (wr_opb && !busy) begin
            opb_d = csr_writedata[WIDTH-1:0];
        end

        case (state_q)
            IDLE: begin
                if (wr_start) begin
                    a_d      = opa_q;
                    b_d      = opb_q;
                    k_d      = '0;
                    cycles_d = '0;
                    if ((opa_q == '0) || (opb_q == '0)) begin
                        gcd_d   = opa_q | opb_q;
                        state_d = DONE;
                    end else begin
                        state_d = STRIP;
                    end
                end
            end

            STRIP: begin
                cycles_d = cycles_inc;
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else begin
                    state_d = REDUCE;
                end
            end

            REDUCE: begin
                cycles_d = cycles_inc;
                if (a_q == b_q) begin
                    gcd_d   = a_q << k_q;
                    state_d = DONE;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    // Both odd here, so the difference is even and the
                    // next cycle always shifts it down.
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end

            DONE: begin
                result_d = gcd_q;
                done_d   = 1'b1;
                if ((opa_q == '0) && (opb_q == '0)) begin
                    zero_err_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (csr_read) begin
            case (csr_address)
                ADDR_CTRL:   rdata_d = {23'd0, irq_en_q, 5'd0, zero_err_q, done_q, busy};
                ADDR_OPA:    rdata_d = zext(opa_q);
                ADDR_OPB:    rdata_d = zext(opb_q);
                ADDR_START:  rdata_d = 32'd0;
                ADDR_RESULT: rdata_d = zext(result_q);
                ADDR_CYCLES: rdata_d = {16'd0, cycles_q};
                ADDR_PARAM:  rdata_d = 32'(WIDTH);
                ADDR_MAGIC:  rdata_d = 32'hDEADBEEF;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            gcd_q      <= '0;
            result_q   <= '0;
            cycles_q   <= '0;
            done_q     <= 1'b0;
            zero_err_q <= 1'b0;
            irq_en_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            gcd_q      <= gcd_d;
            result_q   <= result_d;
            cycles_q   <= cycles_d;
            done_q     <= done_d;
            zero_err_q <= zero_err_d;
            irq_en_q   <= irq_en_d;
            rdata_q    <= rdata_d;
        end
    end

    assign csr_readdata = rdata_q;
    assign irq          = irq_en_q & (done_q | zero_err_q);

endmodule
